// File: rtl/video_in_write.sv
// Video input writer: packs FIFO pixels into NBPACK-byte bursts and writes them
// as 32-bit Wishbone words to a frame buffer, pulsing interrupt when a frame is done.
module video_in_write #(
  parameter int NBPACK   = 16,
  parameter int p_WIDTH  = 640,
  parameter int p_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] wb_reg_data,
  input  logic [31:0] wb_reg_ctr,
  output logic        interrupt,
  output logic [31:0] p_wb_DAT_O,
  input  logic        p_wb_ACK_I,
  output logic        p_wb_STB_O,
  output logic        p_wb_CYC_O,
  output logic        p_wb_LOCK_O,
  output logic [3:0]  p_wb_SEL_O,
  output logic        p_wb_WE_O,
  output logic [31:0] p_wb_ADR_O,
  input  logic        empty,
  output logic        r_e,
  input  logic [7:0]  pixel_in
);
  localparam int FW = $clog2(NBPACK);
  localparam int WW = $clog2(NBPACK / 4) + 1;
  localparam logic [FW:0]   LAST_FILL = (FW + 1)'(NBPACK - 1);
  localparam logic [WW-1:0] NWORDS    = WW'(NBPACK / 4);
  localparam logic [19:0]   FRAME_PIX = 20'(p_WIDTH * p_HEIGHT);

  typedef enum logic [2:0] {
    WAIT_ADDR, FILL, WRITE_RAM, WAIT_ACK, BREAK, IMAGE_DONE
  } state_t;

  state_t        state;
  logic          ctr_q;
  logic          new_addr;
  logic [31:0]   base;
  logic [19:0]   pixel_count;
  logic [FW:0]   fill_cnt;
  logic [WW-1:0] word_idx;
  logic [1:0]    int_cnt;
  logic          stb;
  logic          irq;
  logic [7:0]    pack [NBPACK];
  logic [FW-1:0] pix_idx;
  logic [31:0]   word;

  assign new_addr = wb_reg_ctr[0] & ~ctr_q;
  assign r_e      = (state == FILL) & ~empty & ~RST;

  // Word w of the pack holds pixels 4w..4w+3, first pixel in the top byte.
  assign pix_idx = FW'({word_idx, 2'b00});
  assign word    = {pack[pix_idx], pack[pix_idx + FW'(1)],
                    pack[pix_idx + FW'(2)], pack[pix_idx + FW'(3)]};

  assign p_wb_STB_O  = stb;
  assign p_wb_CYC_O  = stb;
  assign p_wb_WE_O   = stb;
  assign p_wb_LOCK_O = 1'b0;
  assign p_wb_SEL_O  = 4'hf;
  assign p_wb_ADR_O  = stb ? base + {12'd0, pixel_count} : 32'd0;
  assign p_wb_DAT_O  = stb ? word : 32'd0;
  assign interrupt   = irq;

  // Pack storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (r_e) pack[fill_cnt[FW-1:0]] <= pixel_in;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state       <= WAIT_ADDR;
      ctr_q       <= 1'b0;
      base        <= 32'd0;
      pixel_count <= 20'd0;
      fill_cnt    <= '0;
      word_idx    <= '0;
      int_cnt     <= 2'd0;
      stb         <= 1'b0;
      irq         <= 1'b0;
    end else begin
      ctr_q <= wb_reg_ctr[0];
      case (state)
        WAIT_ADDR: begin
          if (new_addr) begin
            base        <= wb_reg_data;
            pixel_count <= 20'd0;
            fill_cnt    <= '0;
            word_idx    <= '0;
            state       <= FILL;
          end
        end
        FILL: begin
          if (r_e) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == LAST_FILL) begin
              word_idx <= '0;
              stb      <= 1'b1;
              state    <= WRITE_RAM;
            end
          end
        end
        WRITE_RAM: state <= WAIT_ACK;
        WAIT_ACK: begin
          if (p_wb_ACK_I) begin
            pixel_count <= pixel_count + 20'd4;
            word_idx    <= word_idx + 1'b1;
            stb         <= 1'b0;
            state       <= BREAK;
          end
        end
        BREAK: begin
          if (word_idx < NWORDS) begin
            stb   <= 1'b1;
            state <= WRITE_RAM;
          end else if (pixel_count == FRAME_PIX) begin
            irq     <= 1'b1;
            int_cnt <= 2'd0;
            state   <= IMAGE_DONE;
          end else begin
            fill_cnt <= '0;
            state    <= FILL;
          end
        end
        IMAGE_DONE: begin
          int_cnt <= int_cnt + 1'b1;
          if (int_cnt == 2'd3) begin
            irq   <= 1'b0;
            state <= WAIT_ADDR;
          end
        end
        default: begin
          stb   <= 1'b0;
          irq   <= 1'b0;
          state <= WAIT_ADDR;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_video_in_write.sv
// Bench for video_in_write: 8x2 frame, 16-pixel packs, FIFO model, Wishbone
// slave with programmable ACK delay and an expected-write queue.
module tb_video_in_write;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_reg_data;
  logic [31:0] wb_reg_ctr;
  logic        interrupt;
  logic [31:0] dat;
  logic        ack = 1'b0;
  logic        stb, cyc, lock, we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic        empty = 1'b1;
  logic        r_e;
  logic [7:0]  pixel_in = 8'h00;

  int total = 0;
  int bad   = 0;

  logic [7:0]  fifo_q[$];
  logic [63:0] exp_q[$];
  int          ack_delay = 1;
  int          wait_cnt  = 0;
  logic [63:0] held;
  logic        hold_fifo = 1'b0;
  logic        burst_en  = 1'b0;
  int          bcnt      = 0;

  video_in_write #(.NBPACK(16), .p_WIDTH(8), .p_HEIGHT(2)) dut (
    .clk(clk), .RST(rst), .wb_reg_data(wb_reg_data), .wb_reg_ctr(wb_reg_ctr),
    .interrupt(interrupt), .p_wb_DAT_O(dat), .p_wb_ACK_I(ack),
    .p_wb_STB_O(stb), .p_wb_CYC_O(cyc), .p_wb_LOCK_O(lock), .p_wb_SEL_O(sel),
    .p_wb_WE_O(we), .p_wb_ADR_O(adr), .empty(empty), .r_e(r_e), .pixel_in(pixel_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // FIFO model: pop on the active edge, present the new head on the falling edge.
  always @(posedge clk) begin
    check("r_e_legal", 64'(r_e & (empty | stb | interrupt)), 64'd0);
    if (r_e && !empty && fifo_q.size() > 0) void'(fifo_q.pop_front());
  end

  always @(negedge clk) begin
    bcnt  = (bcnt + 1) % 6;
    empty = (fifo_q.size() == 0) || hold_fifo || (burst_en && bcnt >= 3);
    pixel_in = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  // Wishbone slave: ACK after ack_delay cycles of STB; bus must hold steady meanwhile.
  always @(negedge clk) begin
    if (stb) begin
      check("cyc_we_with_stb", 64'({cyc, we, sel, lock}), 64'b1111110);
      if (wait_cnt == 0) held = {adr, dat};
      else check("bus_hold", {adr, dat}, held);
      if (wait_cnt == ack_delay) begin
        ack = 1'b1;
        check("write_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check("write_adr_dat", {adr, dat}, exp_q.pop_front());
      end else begin
        ack = 1'b0;
      end
      wait_cnt++;
    end else begin
      ack      = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic load_frame(input logic [31:0] b, input logic [7:0] p0);
    for (int i = 0; i < 16; i++) fifo_q.push_back(p0 + 8'(i));
    for (int w = 0; w < 4; w++)
      exp_q.push_back({b + 32'(4 * w), p0 + 8'(4 * w), p0 + 8'(4 * w + 1),
                       p0 + 8'(4 * w + 2), p0 + 8'(4 * w + 3)});
  endtask

  task automatic pulse_start();
    @(negedge clk) wb_reg_ctr = 32'd1;
    @(negedge clk) wb_reg_ctr = 32'd0;
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    while (!interrupt && n < 800) begin @(negedge clk); n++; end
    check({tag, "_irq_seen"}, 64'(interrupt), 64'd1);
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    n = 0;
    while (interrupt && n < 10) begin @(negedge clk); n++; end
    check({tag, "_irq_len"}, 64'(n), 64'd4);
  endtask

  initial begin
    rst = 1'b1;
    wb_reg_data = 32'h0000_1000;
    wb_reg_ctr  = 32'd1;
    repeat (3) @(negedge clk);
    check("rst_stb", 64'(stb), 64'd0);
    check("rst_cyc", 64'(cyc), 64'd0);
    check("rst_we", 64'(we), 64'd0);
    check("rst_irq", 64'(interrupt), 64'd0);
    check("rst_r_e", 64'(r_e), 64'd0);
    check("rst_adr", 64'(adr), 64'd0);
    check("rst_dat", 64'(dat), 64'd0);

    // Start bit held high through reset release starts exactly one frame.
    load_frame(32'h0000_1000, 8'h00);
    rst = 1'b0;
    wait_frame("basic");
    fifo_q.push_back(8'h55); fifo_q.push_back(8'h66);
    fifo_q.push_back(8'h77); fifo_q.push_back(8'h88);
    repeat (20) @(negedge clk);
    check("no_restart_while_held", 64'(fifo_q.size()), 64'd4);
    fifo_q.delete();
    wb_reg_ctr = 32'd0;
    @(negedge clk);

    burst_en = 1'b1;
    load_frame(32'h0000_1000, 8'h00);
    pulse_start();
    wait_frame("bursty");
    burst_en = 1'b0;

    ack_delay = 5;
    wb_reg_data = 32'h0000_3000;
    load_frame(32'h0000_3000, 8'h40);
    pulse_start();
    wait_frame("slow_slave");
    ack_delay = 1;

    hold_fifo = 1'b1;
    wb_reg_data = 32'h0000_4000;
    load_frame(32'h0000_4000, 8'h80);
    pulse_start();
    repeat (3) @(negedge clk);
    wb_reg_data = 32'h0000_5000;
    pulse_start();
    repeat (3) @(negedge clk);
    hold_fifo = 1'b0;
    wait_frame("ignore_new_addr");

    wb_reg_data = 32'hFFFF_FFF8;
    load_frame(32'hFFFF_FFF8, 8'hA0);
    pulse_start();
    wait_frame("wrap");

    ack_delay = 1000;
    wb_reg_data = 32'h0000_6000;
    load_frame(32'h0000_6000, 8'hC0);
    pulse_start();
    begin
      int n = 0;
      while (!stb && n < 200) begin @(negedge clk); n++; end
      check("stb_before_reset", 64'(stb), 64'd1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midack_rst_stb", 64'(stb), 64'd0);
    check("midack_rst_cyc", 64'(cyc), 64'd0);
    check("midack_rst_adr", 64'(adr), 64'd0);
    check("midack_rst_dat", 64'(dat), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    fifo_q.delete();
    ack_delay = 1;
    @(negedge clk);
    load_frame(32'h0000_6000, 8'hD0);
    pulse_start();
    wait_frame("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
